// File: rtl/blinker_pkg.sv
// Shared types and constants for the blinker pattern master: FSM states and
// the bit layout of a pattern-table entry.
package blinker_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    HOLD
  } state_t;

  localparam int DUR_MSB = 31;
  localparam int DUR_LSB = 8;
  localparam int DUR_W   = DUR_MSB - DUR_LSB + 1;

  localparam logic [3:0] BYTEENABLE_ALL = 4'hF;

endpackage

// File: rtl/blinker_tick_timer.sv
// Duration timer: a prescaler of TICK_DIV cycles feeding a 24-bit tick
// down-counter. expired pulses in the final cycle of a loaded duration.
module blinker_tick_timer
  import blinker_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DUR_W-1:0] duration,
  input  logic             clear,
  output logic             expired
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc;
  logic [DUR_W-1:0]   ticks;
  logic               wrap;

  assign wrap    = (presc == PRESC_LAST);
  // Last cycle of the last tick: a duration of D spans exactly D*TICK_DIV cycles.
  assign expired = wrap && (ticks == DUR_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      presc <= '0;
      ticks <= '0;
    end else if (load) begin
      presc <= '0;
      ticks <= duration;
    end else if (ticks != '0) begin
      if (wrap) begin
        presc <= '0;
        ticks <= ticks - 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/blinker_pattern_master.sv
// Avalon-MM read master that walks a pattern table in on-chip memory and
// shows each entry's pattern on the LEDs for the entry's programmed duration.
module blinker_pattern_master
  import blinker_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int BASE_ADDR   = 0,
  parameter int NUM_ENTRIES = 256,
  parameter int LED_W       = 8,
  parameter int TICK_DIV    = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [LED_W-1:0]  leds,
  output logic              busy,
  output logic [7:0]        entry_idx,
  output logic              table_empty
);

  localparam logic [7:0] IDX_LAST = 8'(NUM_ENTRIES - 1);

  state_t           state, state_next;
  logic [7:0]       idx, idx_next;
  logic [LED_W-1:0] leds_next;
  logic [7:0]       entry_idx_next;
  logic             table_empty_next;
  logic             timer_load, timer_clear, timer_expired;
  logic [DUR_W-1:0] rd_duration;

  assign rd_duration    = avm_readdata[DUR_MSB:DUR_LSB];
  assign avm_address    = ADDR_W'(BASE_ADDR) + ADDR_W'({idx, 2'b00});
  // Dropping enable withdraws an unaccepted request in the same cycle.
  assign avm_read       = (state == REQ) && enable;
  assign avm_byteenable = BYTEENABLE_ALL;
  assign busy           = (state != IDLE);

  blinker_tick_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .duration (rd_duration),
    .clear    (timer_clear),
    .expired  (timer_expired)
  );

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next       = state;
    idx_next         = idx;
    leds_next        = leds;
    entry_idx_next   = entry_idx;
    table_empty_next = table_empty;
    timer_load       = 1'b0;
    timer_clear      = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !table_empty) begin
          state_next = REQ;
          idx_next   = '0;
        end
      end
      REQ: begin
        if (!enable)               state_next = IDLE;
        else if (!avm_waitrequest) state_next = WAIT_DATA;
      end
      WAIT_DATA: begin
        // An accepted read cannot be aborted; a disabled master drops the data.
        if (avm_readdatavalid) begin
          if (!enable) begin
            state_next = IDLE;
          end else if (rd_duration != '0) begin
            leds_next      = avm_readdata[LED_W-1:0];
            entry_idx_next = idx;
            timer_load     = 1'b1;
            state_next     = HOLD;
          end else if (idx != '0) begin
            idx_next   = '0;
            state_next = REQ;
          end else begin
            table_empty_next = 1'b1;
            state_next       = IDLE;
          end
        end
      end
      HOLD: begin
        if (!enable) begin
          timer_clear = 1'b1;
          state_next  = IDLE;
        end else if (timer_expired) begin
          idx_next   = (idx == IDX_LAST) ? 8'd0 : idx + 8'd1;
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      leds        <= '0;
      entry_idx   <= '0;
      table_empty <= 1'b0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      leds        <= leds_next;
      entry_idx   <= entry_idx_next;
      table_empty <= table_empty_next;
    end
  end

endmodule

// File: tb/tb_blinker_pattern_master.sv
// Directed bench for blinker_pattern_master: a small Avalon slave model with
// configurable waitrequest stalls and 1-cycle read latency.
module tb_blinker_pattern_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [13:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic [7:0]  leds;
  logic        busy;
  logic [7:0]  entry_idx;
  logic        table_empty;

  logic [31:0] mem [0:15];
  int          wait_cfg = 0;
  int          wait_left = 0;
  logic        inject_rdv = 1'b0;
  logic [31:0] inject_data = '0;
  logic [13:0] addr_log [$];
  int          len_log [$];
  logic        moved_log [$];
  int          req_cycles = 0;
  logic        req_moved = 1'b0;
  logic [13:0] req_addr = '0;
  logic        s_read, s_wr;
  logic [13:0] s_addr;

  int compared = 0;
  int mismatched = 0;
  int log_base = 0;
  int n;

  blinker_pattern_master #(
    .ADDR_W      (14),
    .BASE_ADDR   (0),
    .NUM_ENTRIES (4),
    .LED_W       (8),
    .TICK_DIV    (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .leds              (leds),
    .busy              (busy),
    .entry_idx         (entry_idx),
    .table_empty       (table_empty)
  );

  always #5 clk = ~clk;

  // Slave model: samples the request at the edge, drives its response 1 time unit later.
  always @(posedge clk) begin
    s_read = avm_read;
    s_wr   = avm_waitrequest;
    s_addr = avm_address;
    #1;
    avm_readdatavalid = 1'b0;
    if (s_read !== 1'b1) begin
      req_cycles = 0;
      req_moved  = 1'b0;
      wait_left  = wait_cfg;
    end else begin
      if (req_cycles > 0 && s_addr != req_addr) req_moved = 1'b1;
      req_addr   = s_addr;
      req_cycles = req_cycles + 1;
      if (s_wr) begin
        if (wait_left > 0) wait_left = wait_left - 1;
      end else begin
        addr_log.push_back(s_addr);
        len_log.push_back(req_cycles);
        moved_log.push_back(req_moved);
        req_cycles        = 0;
        req_moved         = 1'b0;
        wait_left         = wait_cfg;
        avm_readdatavalid = 1'b1;
        avm_readdata      = mem[s_addr[5:2]];
      end
    end
    if (!avm_readdatavalid && inject_rdv) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = inject_data;
    end
    avm_waitrequest = (wait_left > 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_leds(input logic [7:0] exp, input int budget, output int cnt);
    cnt = 0;
    while (leds !== exp && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic cycles_to_read(input int budget, output int cnt);
    cnt = 0;
    while (avm_read !== 1'b1 && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_leds", leds, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_read", avm_read, 1'b0);
    check("rst_entry_idx", entry_idx, 8'd0);
    check("rst_table_empty", table_empty, 1'b0);
    check("byteenable", avm_byteenable, 4'hF);

    // Basic play: A5 for 3 ticks, 5A for 2 ticks, end marker, wrap
    mem[0] = 32'h0000_03A5;
    mem[1] = 32'h0000_025A;
    mem[2] = 32'h0000_0000;
    log_base = addr_log.size();
    enable = 1'b1;
    wait_leds(8'hA5, 20, n);
    check("play_first_leds", leds, 8'hA5);
    check("play_first_latency", n, 3);
    check("play_first_idx", entry_idx, 8'd0);
    cycles_to_read(30, n);
    check("play_hold_a5_cycles", n, 12);
    check("play_addr1", avm_address, 14'd4);
    wait_leds(8'h5A, 10, n);
    check("play_second_leds", leds, 8'h5A);
    check("play_second_latency", n, 2);
    check("play_second_idx", entry_idx, 8'd1);
    cycles_to_read(30, n);
    check("play_hold_5a_cycles", n, 8);
    check("play_addr2", avm_address, 14'd8);
    repeat (2) @(negedge clk);
    check("marker_not_shown", leds, 8'h5A);
    check("marker_rereq_read", avm_read, 1'b1);
    check("marker_rereq_addr", avm_address, 14'd0);
    wait_leds(8'hA5, 5, n);
    check("wrap_leds", leds, 8'hA5);
    check("wrap_latency", n, 2);
    check("wrap_idx", entry_idx, 8'd0);
    check("play_num_reads", addr_log.size() - log_base, 4);
    if (addr_log.size() - log_base >= 4) begin
      check("play_log0", addr_log[log_base], 14'd0);
      check("play_log1", addr_log[log_base + 1], 14'd4);
      check("play_log2", addr_log[log_base + 2], 14'd8);
      check("play_log3", addr_log[log_base + 3], 14'd0);
    end
    enable = 1'b0;
    @(negedge clk);
    check("hold_drop_busy", busy, 1'b0);
    check("hold_drop_leds", leds, 8'hA5);

    // Waitrequest held for 3 cycles
    do_reset();
    wait_cfg = 3;
    log_base = addr_log.size();
    enable = 1'b1;
    wait_leds(8'hA5, 30, n);
    check("wr_leds", leds, 8'hA5);
    check("wr_num_reads", addr_log.size() - log_base, 1);
    if (addr_log.size() - log_base >= 1) begin
      check("wr_read_cycles", len_log[log_base], 4);
      check("wr_addr_stable", moved_log[log_base], 1'b0);
      check("wr_addr", addr_log[log_base], 14'd0);
    end
    enable = 1'b0;
    wait_cfg = 0;
    @(negedge clk);
    check("wr_idle", busy, 1'b0);

    // Empty table
    do_reset();
    mem[0] = 32'h0000_0000;
    log_base = addr_log.size();
    enable = 1'b1;
    repeat (10) @(negedge clk);
    check("empty_flag", table_empty, 1'b1);
    check("empty_busy", busy, 1'b0);
    check("empty_leds", leds, 8'h00);
    check("empty_num_reads", addr_log.size() - log_base, 1);
    if (addr_log.size() - log_base >= 1) check("empty_addr", addr_log[log_base], 14'd0);
    repeat (10) @(negedge clk);
    check("empty_no_more_reads", addr_log.size() - log_base, 1);
    check("empty_sticky", table_empty, 1'b1);
    enable = 1'b0;
    do_reset();
    check("empty_cleared_by_reset", table_empty, 1'b0);

    // Enable drop in WAIT_DATA, coinciding with readdatavalid
    mem[0] = 32'h0000_03A5;
    enable = 1'b1;
    wait_leds(8'hA5, 20, n);
    check("drop_prior_leds", leds, 8'hA5);
    enable = 1'b0;
    @(negedge clk);
    mem[0] = 32'h0000_0511;
    log_base = addr_log.size();
    enable = 1'b1;
    cycles_to_read(5, n);
    check("drop_req_read", avm_read, 1'b1);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("drop_busy", busy, 1'b0);
    check("drop_leds", leds, 8'hA5);
    check("drop_num_reads", addr_log.size() - log_base, 1);
    repeat (5) @(negedge clk);
    check("drop_leds_later", leds, 8'hA5);
    check("drop_entry_idx", entry_idx, 8'd0);
    check("drop_no_read", avm_read, 1'b0);

    // Full-table wrap with NUM_ENTRIES=4, every duration 1
    do_reset();
    mem[0] = 32'h0000_0101;
    mem[1] = 32'h0000_0102;
    mem[2] = 32'h0000_0104;
    mem[3] = 32'h0000_0108;
    mem[4] = 32'h0000_0000;
    log_base = addr_log.size();
    enable = 1'b1;
    n = 0;
    while (addr_log.size() < log_base + 5 && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("full_num_reads", addr_log.size() - log_base, 5);
    if (addr_log.size() - log_base >= 5) begin
      check("full_log0", addr_log[log_base], 14'd0);
      check("full_log1", addr_log[log_base + 1], 14'd4);
      check("full_log2", addr_log[log_base + 2], 14'd8);
      check("full_log3", addr_log[log_base + 3], 14'd12);
      check("full_log4", addr_log[log_base + 4], 14'd0);
    end
    check("full_last_leds", leds, 8'h08);
    check("full_last_idx", entry_idx, 8'd3);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("full_idle", busy, 1'b0);

    // Reset in the middle of a long HOLD
    do_reset();
    mem[0] = 32'h0000_10FF;
    log_base = addr_log.size();
    enable = 1'b1;
    wait_leds(8'hFF, 20, n);
    check("rhold_leds", leds, 8'hFF);
    repeat (5) @(negedge clk);
    check("rhold_in_hold", busy, 1'b1);
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    check("rhold_leds_cleared", leds, 8'h00);
    check("rhold_busy", busy, 1'b0);
    check("rhold_read", avm_read, 1'b0);
    check("rhold_entry_idx", entry_idx, 8'd0);
    reset = 1'b0;
    inject_data = 32'h0000_01AA;
    inject_rdv = 1'b1;
    @(negedge clk);
    inject_rdv = 1'b0;
    repeat (2) @(negedge clk);
    check("late_rdv_leds", leds, 8'h00);
    check("late_rdv_busy", busy, 1'b0);
    log_base = addr_log.size();
    enable = 1'b1;
    n = 0;
    while (addr_log.size() < log_base + 1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("restart_num_reads", addr_log.size() - log_base, 1);
    if (addr_log.size() - log_base >= 1) check("restart_addr", addr_log[log_base], 14'd0);
    wait_leds(8'hFF, 10, n);
    check("restart_leds", leds, 8'hFF);
    enable = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
